// File: rtl/div_pkg.sv
// div_pkg: shared state encoding, default width and counter sizing for the multicycle divider.
package div_pkg;
   localparam int DEFAULT_WIDTH = 32;
   typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, FIX = 2'd2, DONE = 2'd3} state_e;
   function automatic int clog2(input int value);
      int r;
      r = 0;
      for (int v = value - 1; v > 0; v = v >> 1) r++;
      return r;
   endfunction
endpackage

// File: rtl/div_abs_neg.sv
// div_abs_neg: conditional two's-complement negate, used for operand magnitudes and result sign fix.
module div_abs_neg #(
   parameter int WIDTH = 32
) (
   input  logic             negate,
   input  logic [WIDTH-1:0] value,
   output logic [WIDTH-1:0] result
);
   assign result = negate ? -value : value;
endmodule

// File: rtl/signed_multicycle_divider.sv
// signed_multicycle_divider: radix-2 restoring signed divider, one quotient bit per clock.
// Optional DIVIDER_UNSIGNED_MODE_EN adds an is_signed input selecting unsigned operation.
module signed_multicycle_divider
   import div_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
`ifdef DIVIDER_UNSIGNED_MODE_EN
   input  logic             is_signed,
`endif
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             div_by_zero,
   output logic             overflow
);
   localparam int CW = clog2(WIDTH);
   localparam logic [1:0] S_IDLE = IDLE;
   localparam logic [1:0] S_CALC = CALC;
   localparam logic [1:0] S_FIX  = FIX;
   localparam logic [1:0] S_DONE = DONE;
   localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};
   logic mode_signed;
`ifdef DIVIDER_UNSIGNED_MODE_EN
   assign mode_signed = is_signed;
`else
   assign mode_signed = 1'b1;
`endif
   logic [1:0] state;
   logic [CW-1:0] cnt;
   logic [WIDTH-1:0] a_reg, b_mag, pr, a_abs, b_abs, q_fixed, r_fixed, diff;
   logic [WIDTH:0] trial;
   logic sign_q, sign_r, dz_r, ov_r, fix_last, accept, ge;
   assign busy   = (state == S_CALC) || (state == S_FIX);
   assign done   = state == S_DONE;
   assign accept = start && ((state == S_IDLE) || (state == S_DONE));
   // a_reg shifts dividend bits out of its top while quotient bits enter at the bottom
   assign trial = {pr, a_reg[WIDTH-1]};
   assign ge    = trial >= {1'b0, b_mag};
   assign diff  = trial[WIDTH-1:0] - b_mag;
   div_abs_neg #(.WIDTH(WIDTH)) u_abs_a (.negate(mode_signed & dividend[WIDTH-1]), .value(dividend), .result(a_abs));
   div_abs_neg #(.WIDTH(WIDTH)) u_abs_b (.negate(mode_signed & divisor[WIDTH-1]), .value(divisor), .result(b_abs));
   div_abs_neg #(.WIDTH(WIDTH)) u_fix_q (.negate(sign_q), .value(a_reg), .result(q_fixed));
   div_abs_neg #(.WIDTH(WIDTH)) u_fix_r (.negate(sign_r), .value(pr), .result(r_fixed));
   // divide-by-zero needs no special remainder path: subtracting 0 every step leaves |dividend| in pr
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= S_IDLE;
         cnt         <= '0;
         a_reg       <= '0;
         b_mag       <= '0;
         pr          <= '0;
         sign_q      <= 1'b0;
         sign_r      <= 1'b0;
         dz_r        <= 1'b0;
         ov_r        <= 1'b0;
         fix_last    <= 1'b0;
         quotient    <= '0;
         remainder   <= '0;
         div_by_zero <= 1'b0;
         overflow    <= 1'b0;
      end else if (accept) begin
         state       <= S_CALC;
         cnt         <= CW'(WIDTH - 1);
         a_reg       <= a_abs;
         b_mag       <= b_abs;
         pr          <= '0;
         sign_q      <= mode_signed & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
         sign_r      <= mode_signed & dividend[WIDTH-1];
         dz_r        <= divisor == '0;
         ov_r        <= mode_signed && (dividend == MIN_VAL) && (divisor == '1);
         fix_last    <= 1'b0;
         div_by_zero <= 1'b0;
         overflow    <= 1'b0;
      end else if (state == S_CALC) begin
         a_reg <= {a_reg[WIDTH-2:0], ge};
         pr    <= ge ? diff : trial[WIDTH-1:0];
         cnt   <= cnt - 1'b1;
         if (cnt == '0) state <= S_FIX;
      end else if (state == S_FIX) begin
         // two cycles: the first lets the negated results settle, the second publishes them
         fix_last <= ~fix_last;
         if (fix_last) begin
            state       <= S_DONE;
            quotient    <= dz_r ? '1 : q_fixed;
            remainder   <= r_fixed;
            div_by_zero <= dz_r;
            overflow    <= ov_r;
         end
      end else if (state == S_DONE) begin
         state <= S_IDLE;
      end
   end
endmodule

// File: tb/tb_signed_multicycle_divider.sv
// tb_signed_multicycle_divider: directed vectors with a scoreboard queue and a done-driven monitor.
module tb_signed_multicycle_divider;
   localparam int W = 32;
   typedef struct {
      logic [W-1:0] q;
      logic [W-1:0] r;
      logic         dz;
      logic         ov;
      int           cyc;
   } exp_t;
   logic clk = 1'b0, rst = 1'b1, start = 1'b0;
   logic [W-1:0] dividend = '0, divisor = '0;
   logic busy, done, div_by_zero, overflow;
   logic [W-1:0] quotient, remainder;
   int cyc = 0, total = 0, passed = 0;
   exp_t sb[$];
   signed_multicycle_divider #(.WIDTH(W)) dut (
      .clk(clk), .rst(rst), .start(start),
`ifdef DIVIDER_UNSIGNED_MODE_EN
      .is_signed(1'b1),
`endif
      .dividend(dividend), .divisor(divisor), .busy(busy), .done(done),
      .quotient(quotient), .remainder(remainder), .div_by_zero(div_by_zero), .overflow(overflow)
   );
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask
   task automatic check_idle(input string tag);
      check({tag, "_busy"}, 64'(busy), 64'(0));
      check({tag, "_done"}, 64'(done), 64'(0));
      check({tag, "_q"}, 64'(quotient), 64'(0));
      check({tag, "_r"}, 64'(remainder), 64'(0));
      check({tag, "_dz"}, 64'(div_by_zero), 64'(0));
      check({tag, "_ov"}, 64'(overflow), 64'(0));
   endtask
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (!rst && done) begin
            if (sb.size() == 0) check("unexpected_done", 64'(1), 64'(0));
            else begin
               e = sb.pop_front();
               check("quotient", 64'(quotient), 64'(e.q));
               check("remainder", 64'(remainder), 64'(e.r));
               check("div_by_zero", 64'(div_by_zero), 64'(e.dz));
               check("overflow", 64'(overflow), 64'(e.ov));
               check("latency_cycle", 64'(cyc), 64'(e.cyc));
               check("busy_low_at_done", 64'(busy), 64'(0));
            end
         end
      end
   end
   task automatic push(input logic [W-1:0] q, input logic [W-1:0] r, input logic dz, input logic ov);
      sb.push_back('{q: q, r: r, dz: dz, ov: ov, cyc: cyc + 1 + W + 2});
   endtask
   task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] q,
                        input logic [W-1:0] r, input logic dz, input logic ov);
      @(negedge clk);
      start = 1'b1;
      dividend = a;
      divisor = b;
      push(q, r, dz, ov);
      @(negedge clk);
      start = 1'b0;
   endtask
   task automatic drain();
      int n;
      n = 0;
      while (sb.size() != 0 && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (sb.size() != 0) begin
         check("done_timeout", 64'(sb.size()), 64'(0));
         sb.delete();
      end
   endtask
   initial begin
      int n;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      check_idle("reset");
      issue(32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 1'b0); drain();
      issue(-32'sd100, 32'd7, -32'sd14, -32'sd2, 1'b0, 1'b0); drain();
      issue(32'd100, -32'sd7, -32'sd14, 32'd2, 1'b0, 1'b0); drain();
      issue(-32'sd100, -32'sd7, 32'd14, -32'sd2, 1'b0, 1'b0); drain();
      issue(-32'sd7, 32'd2, -32'sd3, -32'sd1, 1'b0, 1'b0); drain();
      issue(-32'sd5, 32'd0, 32'hFFFF_FFFF, -32'sd5, 1'b1, 1'b0); drain();
      issue(32'd0, 32'd0, 32'hFFFF_FFFF, 32'd0, 1'b1, 1'b0); drain();
      issue(32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 1'b0, 1'b1); drain();
      issue(32'h8000_0000, 32'd2, 32'hC000_0000, 32'd0, 1'b0, 1'b0); drain();
      issue(32'd7, 32'd100, 32'd0, 32'd7, 1'b0, 1'b0); drain();
      issue(32'h7FFF_FFFF, 32'h8000_0000, 32'd0, 32'h7FFF_FFFF, 1'b0, 1'b0); drain();
      issue(32'h8000_0000, 32'h8000_0000, 32'd1, 32'd0, 1'b0, 1'b0); drain();
      issue(32'd0, 32'd5, 32'd0, 32'd0, 1'b0, 1'b0); drain();
      // start pulsed mid-calculation must be ignored
      issue(32'd1000, 32'd10, 32'd100, 32'd0, 1'b0, 1'b0);
      repeat (5) @(negedge clk);
      start = 1'b1; dividend = 32'd1; divisor = 32'd1;
      @(negedge clk);
      start = 1'b0;
      drain();
      repeat (40) @(negedge clk);
      // start held through the done cycle launches a second operation back to back
      @(negedge clk);
      start = 1'b1; dividend = 32'd81; divisor = 32'd9;
      push(32'd9, 32'd0, 1'b0, 1'b0);
      n = cyc + 1 + W + 2;
      @(negedge clk);
      dividend = -32'sd81; divisor = 32'd4;
      while (cyc < n) @(negedge clk);
      sb.push_back('{q: -32'sd20, r: -32'sd1, dz: 1'b0, ov: 1'b0, cyc: n + 1 + W + 2});
      @(negedge clk);
      start = 1'b0;
      drain();
      repeat (5) @(negedge clk);
      // reset in the middle of a calculation aborts it with no done pulse
      @(negedge clk);
      start = 1'b1; dividend = 32'd50; divisor = 32'd3;
      @(negedge clk);
      start = 1'b0;
      repeat (9) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check_idle("abort");
      repeat (45) @(negedge clk);
      check("abort_still_idle", 64'(busy), 64'(0));
      issue(32'd200, 32'd7, 32'd28, 32'd4, 1'b0, 1'b0); drain();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1);
   end
endmodule
